sap_fetch_unit: RTL
===================

Name: sap_fetch_unit

Overview:
Fetch-side register stage of the SAP computer. It holds the program counter (PC), the memory address register (MAR) and the instruction register (IR), and feeds the 3-bit opcode to instruction_decoder. It acts on the decoder's inc_PC, ld_MAR, ld_IR and ld_bus strobes, and drives the PC or the IR operand onto the shared bus when selected. It also latches HALT and counts retired fetches.

Parameters:
ADDR_W, 4, width of PC, MAR and IR operand field.
DATA_W, 8, bus and IR width; opcode = IR[DATA_W-1:DATA_W-3].
HLT_OP, 3'b111, opcode value that halts fetch.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
inc_PC  input  1  increment PC this edge.
ld_PC  input  1  load PC from bus_in[ADDR_W-1:0] (jump).
ld_MAR  input  1  load MAR from bus_in[ADDR_W-1:0].
ld_IR  input  1  load IR from bus_in.
ld_bus  input  3  bus source select from decoder.
bus_in  input  DATA_W  shared bus value.
bus_out  output  DATA_W  value driven by this block.
bus_oe  output  1  bus_out valid / block owns bus.
mem_addr  output  ADDR_W  MAR contents to RAM.
opcode  output  3  IR opcode field to instruction_decoder.
operand  output  ADDR_W  IR[ADDR_W-1:0].
pc  output  ADDR_W  current PC.
halted  output  1  HALT latched.
ir_valid  output  1  IR loaded at least once since reset.
fetch_cnt  output  8  number of IR loads, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): pc=0, MAR=0, IR=0, halted=0, ir_valid=0, fetch_cnt=0. Reset mid-operation aborts everything immediately. The first active edge after release behaves normally.
- Register updates happen on the rising clk edge. All outputs are registered except bus_out/bus_oe, which are combinational from ld_bus and the registers.
- PC:
  - ld_PC has priority over inc_PC; if both are high, PC = bus_in[ADDR_W-1:0].
  - inc_PC alone gives PC = PC+1 mod 2^ADDR_W (15 -> 0 wraps silently).
- MAR: on ld_MAR, MAR = bus_in[ADDR_W-1:0]. mem_addr = MAR, valid the cycle after the load.
- IR:
  - On ld_IR, IR = bus_in, ir_valid=1 and fetch_cnt increments, saturating at 255.
  - opcode and operand reflect the new IR one cycle after ld_IR.
- HALT:
  - If ld_IR loads a word whose opcode equals HLT_OP, halted=1 on that same edge.
  - While halted=1: inc_PC, ld_PC, ld_MAR and ld_IR are ignored, all registers hold, and bus_oe is still honoured.
  - Only rst_n clears halted.
- Simultaneous ld_MAR and ld_IR: both load from the same bus_in on that edge.
- Bus select (ld_bus):
  - 3'd1: bus_out = zero-extended PC, bus_oe=1.
  - 3'd2: bus_out = zero-extended operand, bus_oe=1.
  - All other codes: bus_out=0, bus_oe=0.
- This block does not check bus contention; the decoder guarantees a single bus source.
- Latency:
  - Fetch pair T0 (ld_bus=1, ld_MAR) then T1 (inc_PC, ld_IR with RAM data on bus_in).
  - opcode is valid at T2 for the decoder.

Test Plan:
- Reset then release; pulse inc_PC 17 times -> pc reaches 15 then wraps to 0, ending at 1; fetch_cnt=0, ir_valid=0.
- ld_bus=1 with pc=5 -> bus_out=8'h05, bus_oe=1. Same cycle ld_MAR=1, bus_in=8'h05 -> mem_addr=5 next cycle.
- ld_IR with bus_in=8'h29 -> opcode=3'b001 and operand=4'h9 next cycle, ir_valid=1, fetch_cnt=1. Then ld_bus=2 -> bus_out=8'h09.
- ld_PC=1 and inc_PC=1 with bus_in=8'h0C, pc=3 -> pc=12 (jump wins).
- ld_IR with bus_in=8'hE0 -> halted=1. Subsequent inc_PC, ld_IR=8'h20 and ld_MAR=8'h07 -> pc, IR and MAR unchanged, fetch_cnt unchanged.
- Mid-run rst_n low for 3 ns between clock edges -> all outputs 0 immediately, without waiting for clk; 300 consecutive ld_IR pulses afterward -> fetch_cnt saturates at 255.

Source files
------------

// File: rtl/sap_fetch_unit.sv
// -----------------------------------------------------------------------------
// sap_fetch_unit
//
// Fetch-side register stage of the SAP computer. Holds the program counter,
// the memory address register and the instruction register, and hands the IR
// opcode field to the instruction decoder. Acts on the decoder strobes and
// drives either the PC or the IR operand onto the shared bus when selected.
// A fetched HALT opcode freezes all registers until reset. Retired IR loads
// are counted in a saturating counter.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   inc_PC     in   increment PC this edge
//   ld_PC      in   load PC from bus_in (jump); wins over inc_PC
//   ld_MAR     in   load MAR from bus_in
//   ld_IR      in   load IR from bus_in
//   ld_bus     in   bus source select (1 = PC, 2 = IR operand)
//   bus_in     in   shared bus value
//   bus_out    out  value driven by this block (combinational)
//   bus_oe     out  bus_out valid / block owns bus (combinational)
//   mem_addr   out  MAR contents to RAM
//   opcode     out  IR opcode field
//   operand    out  IR operand field
//   pc         out  current PC
//   halted     out  HALT latched
//   ir_valid   out  IR loaded at least once since reset
//   fetch_cnt  out  number of IR loads, saturating at 255
// -----------------------------------------------------------------------------
module sap_fetch_unit #(
    parameter int         ADDR_W = 4,
    parameter int         DATA_W = 8,
    parameter logic [2:0] HLT_OP = 3'b111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_PC,
    input  logic              ld_PC,
    input  logic              ld_MAR,
    input  logic              ld_IR,
    input  logic [2:0]        ld_bus,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              ir_valid,
    output logic [7:0]        fetch_cnt
);

    localparam logic [2:0] BUS_SEL_PC      = 3'd1;
    localparam logic [2:0] BUS_SEL_OPERAND = 3'd2;

    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] mar_q;

    // Register stage. Once halted, every strobe is ignored and all registers
    // hold; only rst_n brings the block back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            mar_q     <= '0;
            ir_q      <= '0;
            halted    <= 1'b0;
            ir_valid  <= 1'b0;
            fetch_cnt <= '0;
        end else if (!halted) begin
            // A jump overrides the sequential increment.
            if (ld_PC) begin
                pc <= bus_in[ADDR_W-1:0];
            end else if (inc_PC) begin
                pc <= pc + 1'b1;
            end

            if (ld_MAR) begin
                mar_q <= bus_in[ADDR_W-1:0];
            end

            if (ld_IR) begin
                ir_q     <= bus_in;
                ir_valid <= 1'b1;
                if (fetch_cnt != 8'hFF) begin
                    fetch_cnt <= fetch_cnt + 8'd1;
                end
                // HALT takes effect on the same edge that loads it.
                if (bus_in[DATA_W-1 -: 3] == HLT_OP) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    assign mem_addr = mar_q;
    assign opcode   = ir_q[DATA_W-1 -: 3];
    assign operand  = ir_q[ADDR_W-1:0];

    // Bus handshake: bus_oe is the valid qualifier for bus_out. There is no
    // ready/back-pressure; when bus_oe is high the value on bus_out is the
    // block's contribution to the bus for this cycle, and when bus_oe is low
    // bus_out is held at zero. Still honoured while halted.
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        case (ld_bus)
            BUS_SEL_PC: begin
                bus_out = {{(DATA_W-ADDR_W){1'b0}}, pc};
                bus_oe  = 1'b1;
            end
            BUS_SEL_OPERAND: begin
                bus_out = {{(DATA_W-ADDR_W){1'b0}}, operand};
                bus_oe  = 1'b1;
            end
            default: begin
                bus_out = '0;
                bus_oe  = 1'b0;
            end
        endcase
    end

endmodule
